// File: rtl/top2_pkg.sv
// Shared types and helpers for the frame top-two scheduler.
package top2_pkg;

    localparam int unsigned TOP2_COUNT_W = 16;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StStream,
        StResult
    } top2_state_e;

    // Round-robin successor of ptr, wrapping at num_req.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned num_req);
        return (ptr + 1 >= num_req) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/frame_top2_scheduler_if.sv
// Requester-side and result-side handshake bundle for frame_top2_scheduler.
interface frame_top2_scheduler_if
    import top2_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 4
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          res_valid;
    logic                          res_ready;
    logic [DATA_WIDTH-1:0]         res_max;
    logic [DATA_WIDTH-1:0]         res_second;
    logic [ID_W-1:0]               res_id;
    logic [TOP2_COUNT_W-1:0]       res_count;

    modport slave (
        input  req_valid, req_data, req_last, res_ready,
        output req_ready, res_valid, res_max, res_second, res_id, res_count
    );

    modport master (
        output req_valid, req_data, req_last, res_ready,
        input  req_ready, res_valid, res_max, res_second, res_id, res_count
    );

endinterface

// File: rtl/top2_tracker.sv
// Running largest/second-largest tracker with saturating beat count.
// Define TOP2_DISTINCT_EN to ignore beats equal to the current max.
module top2_tracker
    import top2_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    clear,
    input  logic                    en,
    input  logic [DATA_WIDTH-1:0]   din,
    output logic [DATA_WIDTH-1:0]   max_o,
    output logic [DATA_WIDTH-1:0]   second_o,
    output logic [TOP2_COUNT_W-1:0] count_o
);

    logic [DATA_WIDTH-1:0]   max_q, max_d;
    logic [DATA_WIDTH-1:0]   second_q, second_d;
    logic [TOP2_COUNT_W-1:0] count_q, count_d;

    always_comb begin
        max_d    = max_q;
        second_d = second_q;
        count_d  = count_q;
        if (clear) begin
            max_d    = '0;
            second_d = '0;
            count_d  = '0;
        end else if (en) begin
            if (din > max_q) begin
                second_d = max_q;
                max_d    = din;
`ifdef TOP2_DISTINCT_EN
            end else if (din < max_q && din > second_q) begin
`else
            end else if (din > second_q) begin
`endif
                second_d = din;
            end
            count_d = (count_q == '1) ? count_q : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            max_q    <= '0;
            second_q <= '0;
            count_q  <= '0;
        end else begin
            max_q    <= max_d;
            second_q <= second_d;
            count_q  <= count_d;
        end
    end

    assign max_o    = max_q;
    assign second_o = second_q;
    assign count_o  = count_q;

endmodule

// File: rtl/frame_top2_scheduler.sv
// Round-robin frame scheduler feeding a shared top-two tracker.
// TOP2_DISTINCT_EN (see top2_tracker) selects distinct-second behaviour.
module frame_top2_scheduler
    import top2_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    frame_top2_scheduler_if.slave bus
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    top2_state_e         state_q;
    logic [ID_W-1:0]     grant_q;
    logic [ID_W-1:0]     rr_ptr_q;
    logic [NUM_REQ-1:0]  req_ready_q;
    logic                res_valid_q;

    logic                win_found;
    logic [ID_W-1:0]     win_idx;
    int unsigned         cand;
    logic [DATA_WIDTH-1:0] din;
    logic                beat_acc;
    logic                beat_last;
    logic                res_hs;

    // First valid requester at or after rr_ptr_q.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 32'(rr_ptr_q);
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!win_found && bus.req_valid[cand[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[ID_W-1:0];
            end
            cand = next_ptr(cand, NUM_REQ);
        end
    end

    assign din       = bus.req_data[32'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
    assign beat_acc  = bus.req_valid[grant_q] & req_ready_q[grant_q];
    assign beat_last = bus.req_last[grant_q];
    assign res_hs    = (state_q == StResult) & bus.res_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            req_ready_q <= '0;
            res_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (win_found) begin
                        grant_q <= win_idx;
                        state_q <= StGrant;
                    end
                end
                StGrant: begin
                    req_ready_q <= NUM_REQ'(1) << grant_q;
                    state_q     <= StStream;
                end
                StStream: begin
                    if (beat_acc && beat_last) begin
                        req_ready_q <= '0;
                        res_valid_q <= 1'b1;
                        state_q     <= StResult;
                    end
                end
                StResult: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        rr_ptr_q    <= ID_W'(next_ptr(32'(grant_q), NUM_REQ));
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    top2_tracker #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tracker (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (res_hs),
        .en       (beat_acc),
        .din      (din),
        .max_o    (bus.res_max),
        .second_o (bus.res_second),
        .count_o  (bus.res_count)
    );

    assign bus.req_ready = req_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = grant_q;

endmodule
